// File: rtl/bin_bcd_display_scan.sv
// bin_bcd_display_scan
//   Takes an N-bit binary value and converts it to two BCD digits with a
//   sequential shift-add-3 (double-dabble) FSM. The result is shown on digits
//   0 (units) and 1 (tens) of a 4-digit, active-low, seven-segment display
//   using time-multiplexed scanning.
// Ports
//   clk        system clock; all state changes on its rising edge
//   rst        asynchronous, active-high reset
//   bin_in     [N-1:0] binary value to convert
//   bin_valid  conversion request; sampled only while idle
//   busy       high while a conversion is in flight
//   bcd_units  [3:0] units digit of the last completed conversion
//   bcd_tens   [3:0] tens digit of the last completed conversion
//   seg        [6:0] {a,b,c,d,e,f,g}, active low, registered
//   an         [3:0] anode enables, active low, registered
//   dp         decimal point, active low; always off
module bin_bcd_display_scan #(
  parameter int N           = 4,
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] bin_in,
  input  logic         bin_valid,
  output logic         busy,
  output logic [3:0]   bcd_units,
  output logic [3:0]   bcd_tens,
  output logic [6:0]   seg,
  output logic [3:0]   an,
  output logic         dp
);

  localparam int CW = $clog2(N + 1);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] NBITS = CW'(N);
  localparam logic [RW-1:0] RMAX  = RW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [N-1:0]    r_shreg;
  logic [7:0]      r_scratch;
  logic [CW-1:0]   r_bitcnt;
  logic [7:0]      w_adj;
  logic [RW-1:0]   r_refresh;
  logic            r_sel;
  logic [3:0]      w_an;
  logic [6:0]      w_seg;

  function automatic logic [6:0] seg_pat(input logic [3:0] d);
    case (d)
      4'd0:    seg_pat = 7'b000_0001;
      4'd1:    seg_pat = 7'b100_1111;
      4'd2:    seg_pat = 7'b001_0010;
      4'd3:    seg_pat = 7'b000_0110;
      4'd4:    seg_pat = 7'b100_1100;
      4'd5:    seg_pat = 7'b010_0100;
      4'd6:    seg_pat = 7'b010_0000;
      4'd7:    seg_pat = 7'b000_1111;
      4'd8:    seg_pat = 7'b000_0000;
      4'd9:    seg_pat = 7'b000_0100;
      default: seg_pat = 7'b111_1111;
    endcase
  endfunction

  // ---------------- conversion FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // SHIFT lasts N+1 cycles: N shifting cycles plus one cycle in which the
  // counter has reached N and the FSM moves on, so busy spans N+2 cycles.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bin_valid) w_next = S_SHIFT;
      S_SHIFT: if (r_bitcnt == NBITS) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign busy = (r_state != S_IDLE);

  // add-3 correction on each nibble before it is doubled
  always_comb begin
    w_adj[3:0] = (r_scratch[3:0] >= 4'd5) ? 4'(r_scratch[3:0] + 4'd3) : r_scratch[3:0];
    w_adj[7:4] = (r_scratch[7:4] >= 4'd5) ? 4'(r_scratch[7:4] + 4'd3) : r_scratch[7:4];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg   <= '0;
      r_scratch <= '0;
      r_bitcnt  <= '0;
      bcd_units <= '0;
      bcd_tens  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bin_valid) begin
          r_shreg   <= bin_in;
          r_scratch <= '0;
          r_bitcnt  <= '0;
        end
        S_SHIFT: if (r_bitcnt != NBITS) begin
          {r_scratch, r_shreg} <= {w_adj[6:0], r_shreg, 1'b0};
          r_bitcnt             <= r_bitcnt + CW'(1);
        end
        S_DONE: begin
          // both digits on the same edge so a reader never sees a torn value
          bcd_tens  <= r_scratch[7:4];
          bcd_units <= r_scratch[3:0];
        end
        default: ;
      endcase
    end
  end

  // ---------------- display scan ----------------
  always_comb begin
    if (!r_sel) begin
      w_an  = 4'b1110;
      w_seg = seg_pat(bcd_units);
    end else begin
      w_an  = (BLANK_LZ && bcd_tens == 4'd0) ? 4'b1111 : 4'b1101;
      w_seg = seg_pat(bcd_tens);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_refresh <= '0;
      r_sel     <= 1'b0;
      an        <= 4'b1110;
      seg       <= 7'b000_0001;
    end else begin
      if (r_refresh == RMAX) begin
        r_refresh <= '0;
        r_sel     <= ~r_sel;
      end else begin
        r_refresh <= r_refresh + RW'(1);
      end
      an  <= w_an;
      seg <= w_seg;
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_bin_bcd_display_scan.sv
module tb_bin_bcd_display_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] bin_in;
  logic       bin_valid;

  logic       busy_a, busy_b, dp_a, dp_b;
  logic [3:0] units_a, tens_a, an_a, units_b, tens_b, an_b;
  logic [6:0] seg_a, seg_b;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  // a: leading-zero blanking on; b: tens always shown
  bin_bcd_display_scan #(.N(4), .REFRESH_DIV(4), .BLANK_LZ(1'b1)) u_a (
    .clk(clk), .rst(rst), .bin_in(bin_in), .bin_valid(bin_valid),
    .busy(busy_a), .bcd_units(units_a), .bcd_tens(tens_a),
    .seg(seg_a), .an(an_a), .dp(dp_a));

  bin_bcd_display_scan #(.N(4), .REFRESH_DIV(4), .BLANK_LZ(1'b0)) u_b (
    .clk(clk), .rst(rst), .bin_in(bin_in), .bin_valid(bin_valid),
    .busy(busy_b), .bcd_units(units_b), .bcd_tens(tens_b),
    .seg(seg_b), .an(an_b), .dp(dp_b));

  // start a conversion with a one-cycle request and count busy cycles
  task automatic do_convert(input logic [3:0] v, output int cyc);
    @(negedge clk);
    bin_in = v; bin_valid = 1'b1;
    @(negedge clk);
    bin_valid = 1'b0;
    cyc = 0;
    while (busy_a && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic wait_an_a(input logic [3:0] want, output bit found);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (an_a === want) found = 1'b1;
    end
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #1;
    vectors++; if (an_a !== 4'b1110) begin errors++; $display("FAIL reset_an got=%b exp=1110", an_a); end
    vectors++; if (seg_a !== 7'b0000001) begin errors++; $display("FAIL reset_seg got=%b exp=0000001", seg_a); end
    vectors++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
    vectors++; if (dp_a !== 1'b1 || dp_b !== 1'b1) begin errors++; $display("FAIL reset_dp got=%b/%b exp=1", dp_a, dp_b); end
    vectors++; if ({tens_a, units_a} !== 8'h00) begin errors++; $display("FAIL reset_bcd got=%h exp=00", {tens_a, units_a}); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_convert13;
    int cyc;
    do_convert(4'd13, cyc);
    vectors++; if (cyc != 6) begin errors++; $display("FAIL busy_len13 got=%0d exp=6", cyc); end
    vectors++; if (tens_a !== 4'd1 || units_a !== 4'd3) begin errors++; $display("FAIL bcd13 got=%0d%0d exp=13", tens_a, units_a); end
  endtask

  task automatic test_scan13;
    bit found = 1'b0;
    logic [3:0] prev = an_a;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (prev === 4'b1101 && an_a === 4'b1110) found = 1'b1;
      prev = an_a;
    end
    vectors++; if (!found) begin errors++; $display("FAIL scan_sync got=%b exp=1110 after 1101", an_a); end
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      vectors++;
      if (i < 4 && (an_a !== 4'b1110 || seg_a !== 7'b0000110)) begin
        errors++; $display("FAIL scan_units%0d got=%b/%b exp=1110/0000110", i, an_a, seg_a);
      end else if (i >= 4 && (an_a !== 4'b1101 || seg_a !== 7'b1001111)) begin
        errors++; $display("FAIL scan_tens%0d got=%b/%b exp=1101/1001111", i, an_a, seg_a);
      end
    end
  endtask

  task automatic test_blank9;
    int cyc;
    bit found;
    do_convert(4'd9, cyc);
    vectors++; if (tens_a !== 4'd0 || units_a !== 4'd9) begin errors++; $display("FAIL bcd9 got=%0d%0d exp=09", tens_a, units_a); end
    wait_an_a(4'b1111, found);
    vectors++; if (!found) begin errors++; $display("FAIL blank9_an got=%b exp=1111", an_a); end
    vectors++; if (an_b !== 4'b1101 || seg_b !== 7'b0000001) begin errors++; $display("FAIL noblank9 got=%b/%b exp=1101/0000001", an_b, seg_b); end
    wait_an_a(4'b1110, found);
    vectors++; if (!found || seg_a !== 7'b0000100 || seg_b !== 7'b0000100) begin
      errors++; $display("FAIL units9 got=%b/%b exp=0000100", seg_a, seg_b);
    end
  endtask

  task automatic test_ignore_busy;
    int cyc;
    @(negedge clk);
    bin_in = 4'd15; bin_valid = 1'b1;
    @(negedge clk);            // first busy cycle
    bin_valid = 1'b0;
    @(negedge clk);            // second busy cycle
    bin_in = 4'd7; bin_valid = 1'b1;
    @(negedge clk);
    bin_valid = 1'b0;
    cyc = 2;
    while (busy_a && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    vectors++; if (cyc != 6) begin errors++; $display("FAIL busy_len15 got=%0d exp=6", cyc); end
    vectors++; if (tens_a !== 4'd1 || units_a !== 4'd5) begin errors++; $display("FAIL bcd15 got=%0d%0d exp=15", tens_a, units_a); end
    repeat (8) @(negedge clk);
    vectors++; if (busy_a !== 1'b0 || units_a !== 4'd5) begin errors++; $display("FAIL no_queue got=%b/%0d exp=0/5", busy_a, units_a); end
  endtask

  task automatic test_back_to_back;
    int cyc = 0;
    int gap = 0;
    @(negedge clk);
    bin_in = 4'd13; bin_valid = 1'b1;
    @(negedge clk);
    while (busy_a && cyc < 40) begin cyc++; @(negedge clk); end
    vectors++; if (tens_a !== 4'd1 || units_a !== 4'd3) begin errors++; $display("FAIL b2b_first got=%0d%0d exp=13", tens_a, units_a); end
    bin_in = 4'd6;
    while (!busy_a && gap < 40) begin gap++; @(negedge clk); end
    vectors++; if (gap != 1) begin errors++; $display("FAIL b2b_gap got=%0d exp=1", gap); end
    bin_valid = 1'b0;
    cyc = 0;
    while (busy_a && cyc < 40) begin cyc++; @(negedge clk); end
    vectors++; if (tens_a !== 4'd0 || units_a !== 4'd6) begin errors++; $display("FAIL b2b_second got=%0d%0d exp=06", tens_a, units_a); end
  endtask

  task automatic test_rst_mid_shift;
    int cyc;
    bit found;
    @(negedge clk);
    bin_in = 4'd11; bin_valid = 1'b1;
    @(negedge clk);
    bin_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++; if (busy_a !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy_a); end
    vectors++; if ({tens_a, units_a} !== 8'h00) begin errors++; $display("FAIL midrst_bcd got=%h exp=00", {tens_a, units_a}); end
    vectors++; if (an_a !== 4'b1110 || seg_a !== 7'b0000001 || dp_a !== 1'b1) begin
      errors++; $display("FAIL midrst_disp got=%b/%b/%b exp=1110/0000001/1", an_a, seg_a, dp_a);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    vectors++; if (busy_a !== 1'b0 || {tens_a, units_a} !== 8'h00) begin
      errors++; $display("FAIL discard got=%b/%h exp=0/00", busy_a, {tens_a, units_a});
    end
    do_convert(4'd0, cyc);
    vectors++; if (cyc != 6 || {tens_a, units_a} !== 8'h00) begin errors++; $display("FAIL conv0 got=%0d/%h exp=6/00", cyc, {tens_a, units_a}); end
    wait_an_a(4'b1111, found);
    vectors++; if (!found) begin errors++; $display("FAIL blank0_an got=%b exp=1111", an_a); end
    wait_an_a(4'b1110, found);
    vectors++; if (!found || seg_a !== 7'b0000001) begin errors++; $display("FAIL units0 got=%b exp=0000001", seg_a); end
  endtask

  initial begin
    rst = 1'b0; bin_in = '0; bin_valid = 1'b0;
    test_reset;
    test_convert13;
    test_scan13;
    test_blank9;
    test_ignore_busy;
    test_back_to_back;
    test_rst_mid_shift;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
